// File: rtl/wall_probe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wall_probe_pkg
//  Description : Shared constants, state codes and edge type for wall_probe.
//  Revision    : 1.0 - initial release
// ============================================================================
package wall_probe_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int MAX_X    = 639;
    localparam int MAX_Y    = 479;
    localparam int COORD_W  = 10;
    localparam int K_W      = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN_L = 3'd1;
    localparam logic [2:0] ST_SCAN_R = 3'd2;
    localparam logic [2:0] ST_SCAN_U = 3'd3;
    localparam logic [2:0] ST_SCAN_D = 3'd4;

    typedef enum logic [1:0] {
        EDGE_L = 2'd0,
        EDGE_R = 2'd1,
        EDGE_U = 2'd2,
        EDGE_D = 2'd3
    } edge_e;

    // Clamp a signed coordinate into 0..max_v.
    function automatic logic [COORD_W-1:0] sat_coord(input logic signed [11:0] v,
                                                     input logic signed [11:0] max_v);
        logic [COORD_W-1:0] r;
        if (v < 12'sd0)
            r = '0;
        else if (v > max_v)
            r = max_v[COORD_W-1:0];
        else
            r = v[COORD_W-1:0];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wall_probe_if.sv
`default_nettype none
// ============================================================================
//  Module      : wall_probe_if
//  Description : Request/result and map-query signals of the wall prober.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wall_probe_if;
    import wall_probe_pkg::*;

    logic               start;
    logic [COORD_W-1:0] Pos_X;
    logic [COORD_W-1:0] Pos_Y;
    logic [COORD_W-1:0] Probe_X;
    logic [COORD_W-1:0] Probe_Y;
    logic               Probe_is_Wall;
    logic               busy;
    logic               done;
    logic               Block_L;
    logic               Block_R;
    logic               Block_U;
    logic               Block_D;

    modport master (
        output start, Pos_X, Pos_Y, Probe_is_Wall,
        input  Probe_X, Probe_Y, busy, done, Block_L, Block_R, Block_U, Block_D
    );

    modport slave (
        input  start, Pos_X, Pos_Y, Probe_is_Wall,
        output Probe_X, Probe_Y, busy, done, Block_L, Block_R, Block_U, Block_D
    );
endinterface
`default_nettype wire

// File: rtl/wall_probe_probe_coord_gen.sv
`default_nettype none
// ============================================================================
//  Module      : probe_coord_gen
//  Description : Saturated probe coordinate for a given edge and probe index.
//  Revision    : 1.0 - initial release
// ============================================================================
module probe_coord_gen
    import wall_probe_pkg::*;
#(
    parameter int SPRITE_W = 20,
    parameter int SPRITE_H = 30,
    parameter int N_PROBE  = 4
) (
    input  logic [COORD_W-1:0] i_pos_x,
    input  logic [COORD_W-1:0] i_pos_y,
    input  edge_e              i_edge,
    input  logic [K_W-1:0]     i_k,
    output logic [COORD_W-1:0] o_probe_x,
    output logic [COORD_W-1:0] o_probe_y
);
    localparam int STEP_W = (SPRITE_W - 1) / (N_PROBE - 1);
    localparam int STEP_H = (SPRITE_H - 1) / (N_PROBE - 1);

    logic               w_last;
    logic signed [11:0] w_base_x;
    logic signed [11:0] w_base_y;
    logic signed [11:0] w_off_w;
    logic signed [11:0] w_off_h;
    logic signed [11:0] w_x;
    logic signed [11:0] w_y;

    // One guard bit above the 11-bit signed range keeps far-right/bottom sums from wrapping.
    assign w_base_x = $signed({2'b00, i_pos_x});
    assign w_base_y = $signed({2'b00, i_pos_y});
    assign w_last   = (i_k == K_W'(N_PROBE - 1));
    assign w_off_w  = w_last ? 12'(SPRITE_W - 1) : 12'(32'(i_k) * STEP_W);
    assign w_off_h  = w_last ? 12'(SPRITE_H - 1) : 12'(32'(i_k) * STEP_H);

    always_comb begin
        w_x = w_base_x;
        w_y = w_base_y;
        case (i_edge)
            EDGE_L: begin w_x = w_base_x - 12'sd1;          w_y = w_base_y + w_off_h; end
            EDGE_R: begin w_x = w_base_x + 12'(SPRITE_W);   w_y = w_base_y + w_off_h; end
            EDGE_U: begin w_x = w_base_x + w_off_w;         w_y = w_base_y - 12'sd1;  end
            EDGE_D: begin w_x = w_base_x + w_off_w;         w_y = w_base_y + 12'(SPRITE_H); end
            default: begin w_x = w_base_x;                  w_y = w_base_y;           end
        endcase
    end

    assign o_probe_x = sat_coord(w_x, 12'(MAX_X));
    assign o_probe_y = sat_coord(w_y, 12'(MAX_Y));

endmodule
`default_nettype wire

// File: rtl/wall_probe.sv
`default_nettype none
// ============================================================================
//  Module      : wall_probe
//  Description : Per-frame edge prober producing left/right/up/down blocked flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module wall_probe
    import wall_probe_pkg::*;
#(
    parameter int SPRITE_W = 20,
    parameter int SPRITE_H = 30,
    parameter int N_PROBE  = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    wall_probe_if.slave  bus
);
    logic [2:0]         r_state_q,   w_state_d;
    logic [K_W-1:0]     r_k_q,       w_k_d;
    logic [COORD_W-1:0] r_pos_x_q,   w_pos_x_d;
    logic [COORD_W-1:0] r_pos_y_q,   w_pos_y_d;
    logic [3:0]         r_shadow_q,  w_shadow_d;
    logic [3:0]         r_block_q,   w_block_d;
    logic [COORD_W-1:0] r_probe_x_q, w_probe_x_d;
    logic [COORD_W-1:0] r_probe_y_q, w_probe_y_d;
    logic               r_done_q,    w_done_d;

    edge_e              w_cur_edge;
    edge_e              w_gen_edge;
    logic               w_last_k;
    logic [K_W-1:0]     w_gen_k;
    logic [COORD_W-1:0] w_gen_x, w_gen_y;
    logic [COORD_W-1:0] w_gen_px, w_gen_py;

    always_comb begin
        case (r_state_q)
            ST_SCAN_R: w_cur_edge = EDGE_R;
            ST_SCAN_U: w_cur_edge = EDGE_U;
            ST_SCAN_D: w_cur_edge = EDGE_D;
            default:   w_cur_edge = EDGE_L;
        endcase
    end

    assign w_last_k = (r_k_q == K_W'(N_PROBE - 1));

    // The generator always looks one probe ahead so the coordinate is registered in time.
    always_comb begin
        w_gen_x    = r_pos_x_q;
        w_gen_y    = r_pos_y_q;
        w_gen_edge = w_cur_edge;
        w_gen_k    = r_k_q + K_W'(1);
        if (r_state_q == ST_IDLE) begin
            w_gen_x    = bus.Pos_X;
            w_gen_y    = bus.Pos_Y;
            w_gen_edge = EDGE_L;
            w_gen_k    = '0;
        end else if (w_last_k) begin
            w_gen_edge = edge_e'(w_cur_edge + 2'd1);
            w_gen_k    = '0;
        end
    end

    probe_coord_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .N_PROBE  (N_PROBE)
    ) u_coord_gen (
        .i_pos_x   (w_gen_x),
        .i_pos_y   (w_gen_y),
        .i_edge    (w_gen_edge),
        .i_k       (w_gen_k),
        .o_probe_x (w_gen_px),
        .o_probe_y (w_gen_py)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_k_d       = r_k_q;
        w_pos_x_d   = r_pos_x_q;
        w_pos_y_d   = r_pos_y_q;
        w_shadow_d  = r_shadow_q;
        w_block_d   = r_block_q;
        w_probe_x_d = r_probe_x_q;
        w_probe_y_d = r_probe_y_q;
        w_done_d    = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_d   = ST_SCAN_L;
                    w_pos_x_d   = bus.Pos_X;
                    w_pos_y_d   = bus.Pos_Y;
                    w_shadow_d  = '0;
                    w_k_d       = '0;
                    w_probe_x_d = w_gen_px;
                    w_probe_y_d = w_gen_py;
                end
            end
            ST_SCAN_L, ST_SCAN_R, ST_SCAN_U, ST_SCAN_D: begin
                w_shadow_d[w_cur_edge] = r_shadow_q[w_cur_edge] | bus.Probe_is_Wall;
                w_k_d = w_last_k ? '0 : r_k_q + K_W'(1);
                if (w_last_k && r_state_q == ST_SCAN_D) begin
                    w_state_d = ST_IDLE;
                    w_block_d = w_shadow_d;
                    w_done_d  = 1'b1;
                end else begin
                    if (w_last_k)
                        w_state_d = r_state_q + 3'd1;
                    w_probe_x_d = w_gen_px;
                    w_probe_y_d = w_gen_py;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state_q   <= ST_IDLE;
            r_k_q       <= '0;
            r_pos_x_q   <= '0;
            r_pos_y_q   <= '0;
            r_shadow_q  <= '0;
            r_block_q   <= '0;
            r_probe_x_q <= '0;
            r_probe_y_q <= '0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_k_q       <= w_k_d;
            r_pos_x_q   <= w_pos_x_d;
            r_pos_y_q   <= w_pos_y_d;
            r_shadow_q  <= w_shadow_d;
            r_block_q   <= w_block_d;
            r_probe_x_q <= w_probe_x_d;
            r_probe_y_q <= w_probe_y_d;
            r_done_q    <= w_done_d;
        end
    end

    assign bus.Probe_X = r_probe_x_q;
    assign bus.Probe_Y = r_probe_y_q;
    assign bus.busy    = (r_state_q != ST_IDLE);
    assign bus.done    = r_done_q;
    assign bus.Block_L = r_block_q[0];
    assign bus.Block_R = r_block_q[1];
    assign bus.Block_U = r_block_q[2];
    assign bus.Block_D = r_block_q[3];

endmodule
`default_nettype wire

// File: tb/tb_wall_probe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wall_probe
//  Description : Self-checking bench for wall_probe with a behavioural wall map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wall_probe;
    import wall_probe_pkg::*;

    localparam int SW   = 20;
    localparam int SH   = 30;
    localparam int NP   = 4;
    localparam int NPTS = 4 * NP;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;

    wall_probe_if bus ();

    wall_probe #(
        .SPRITE_W (SW),
        .SPRITE_H (SH),
        .N_PROBE  (NP)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // Playfield: border walls, floor, a platform and a small test block.
    function automatic logic is_wall(input int x, input int y);
        return (x < 25) || (x > 614) || (y < 25) || (y >= 455) ||
               (x >= 50 && x <= 250 && y >= 391 && y <= 395) ||
               (x >= 565 && x <= 580 && y >= 420 && y <= 440);
    endfunction

    assign bus.Probe_is_Wall = is_wall(int'(bus.Probe_X), int'(bus.Probe_Y));

    int errors = 0;
    int checks = 0;

    int         exp_px [NPTS];
    int         exp_py [NPTS];
    logic [3:0] exp_blk;
    logic [3:0] held_blk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic build_model(input int x0, input int y0);
        int off_h, off_w, x, y;
        exp_blk = '0;
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < NP; k++) begin
                off_h = (k == NP - 1) ? SH - 1 : k * ((SH - 1) / (NP - 1));
                off_w = (k == NP - 1) ? SW - 1 : k * ((SW - 1) / (NP - 1));
                case (e)
                    0:       begin x = x0 - 1;     y = y0 + off_h; end
                    1:       begin x = x0 + SW;    y = y0 + off_h; end
                    2:       begin x = x0 + off_w; y = y0 - 1;     end
                    default: begin x = x0 + off_w; y = y0 + SH;    end
                endcase
                exp_px[e*NP + k] = clamp(x, SCREEN_W - 1);
                exp_py[e*NP + k] = clamp(y, SCREEN_H - 1);
                if (is_wall(exp_px[e*NP + k], exp_py[e*NP + k]))
                    exp_blk[e] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] blk_now();
        return 32'({bus.Block_D, bus.Block_U, bus.Block_R, bus.Block_L});
    endfunction

    // Caller is mid-cycle; start is presented for the next rising edge (E0).
    task automatic run_scan(input int x0, input int y0, input int repulse_at);
        build_model(x0, y0);
        bus.Pos_X = 10'(x0);
        bus.Pos_Y = 10'(y0);
        bus.start = 1'b1;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        for (int j = 0; j < NPTS; j++) begin
            if (j > 0) begin
                @(posedge Clk); #1;
                bus.start = 1'b0;
            end
            if (j == repulse_at) begin
                bus.start = 1'b1;
                bus.Pos_X = 10'($urandom_range(0, 639));
                bus.Pos_Y = 10'($urandom_range(0, 479));
            end
            chk($sformatf("probe_x[%0d]", j), 32'(bus.Probe_X), exp_px[j]);
            chk($sformatf("probe_y[%0d]", j), 32'(bus.Probe_Y), exp_py[j]);
            chk($sformatf("busy[%0d]", j),    32'(bus.busy),    1);
            chk($sformatf("done_early[%0d]", j), 32'(bus.done), 0);
            chk($sformatf("block_hold[%0d]", j), blk_now(),     32'(held_blk));
        end
        @(posedge Clk); #1;
        bus.start = 1'b0;
        chk("done_pulse", 32'(bus.done), 1);
        chk("busy_done",  32'(bus.busy), 0);
        chk("block_flags", blk_now(), 32'(exp_blk));
        held_blk = exp_blk;
    endtask

    task automatic idle_cycle();
        @(posedge Clk); #1;
        chk("done_clear", 32'(bus.done), 0);
        chk("idle_busy",  32'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        held_blk  = '0;
        bus.start = 1'b0;
        bus.Pos_X = '0;
        bus.Pos_Y = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy",    32'(bus.busy),    0);
        chk("rst_done",    32'(bus.done),    0);
        chk("rst_block",   blk_now(),        0);
        chk("rst_probe_x", 32'(bus.Probe_X), 0);
        chk("rst_probe_y", 32'(bus.Probe_Y), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        run_scan(300, 200, -1);
        chk("open_field", blk_now(), 32'b0000);
        idle_cycle();
        run_scan(300, 425, -1);
        chk("floor", blk_now(), 32'b1000);
        run_scan(25, 200, -1);
        chk("left_wall", blk_now(), 32'b0001);
        run_scan(100, 361, -1);
        chk("platform_d", 32'(bus.Block_D), 1);
        run_scan(545, 395, -1);
        chk("test_block", blk_now(), 32'b0010);
        idle_cycle();
        run_scan(0, 0, -1);
        chk("origin_l", 32'(bus.Block_L), 1);
        chk("origin_u", 32'(bus.Block_U), 1);
        idle_cycle();
        run_scan(300, 200, 5);
        idle_cycle();

        for (int n = 0; n < 6; n++)
            run_scan(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), -1);
        idle_cycle();

        // Reset mid-scan after a scan that published nonzero flags.
        run_scan(0, 0, -1);
        bus.Pos_X = 10'd300;
        bus.Pos_Y = 10'd425;
        bus.start = 1'b1;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("arst_busy",    32'(bus.busy),    0);
        chk("arst_done",    32'(bus.done),    0);
        chk("arst_block",   blk_now(),        0);
        chk("arst_probe_x", 32'(bus.Probe_X), 0);
        chk("arst_probe_y", 32'(bus.Probe_Y), 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk); #1;
            chk("post_rst_done", 32'(bus.done), 0);
        end
        chk("post_rst_block", blk_now(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wall_probe.md
# wall_probe

Sequential collision prober that queries the playfield wall map for one character per frame. Given a sprite's top-left position, it walks probe points just outside each edge of the sprite's bounding box. For each point it drives a coordinate into a dedicated map-query instance and samples that instance's wall flag. At the end it publishes registered left/right/up/down blocked flags that the character motion logic uses before committing a move.

## Interface
- SPRITE_W, 20: sprite width in pixels (≥2)
- SPRITE_H, 30: sprite height in pixels (≥2)
- N_PROBE, 4: probe points per edge (2..8)
- Clk  in  1: system clock
- Reset_n  in  1: asynchronous, active-low reset
- start  in  1: one-cycle request to begin a scan; accepted only when busy=0
- Pos_X  in  10: sprite left column, latched on accepted start
- Pos_Y  in  10: sprite top row, latched on accepted start
- Probe_X  out  10: registered query column to the map-query instance
- Probe_Y  out  10: registered query row to the map-query instance
- Probe_is_Wall  in  1: combinational wall flag for (Probe_X, Probe_Y)
- busy  out  1: scan in progress
- done  out  1: one-cycle pulse; flags updated in the same cycle
- Block_L, Block_R, Block_U, Block_D  out  1 each: published blocked flags

## Operation
- States: IDLE, SCAN_L, SCAN_R, SCAN_U, SCAN_D.
- IDLE + start:
  - latch Pos_X and Pos_Y;
  - clear shadow flags and probe index k;
  - enter SCAN_L.
- Each SCAN state issues N_PROBE probes, k = 0..N_PROBE-1. It moves to the next edge after k = N_PROBE-1. SCAN_D returns to IDLE.
- Probe coordinates:
  - Left: X = Pos_X-1, Y = Pos_Y+k·stepH.
  - Right: X = Pos_X+SPRITE_W, Y as for left.
  - Top: Y = Pos_Y-1, X = Pos_X+k·stepW.
  - Bottom: Y = Pos_Y+SPRITE_H, X as for top.
- Step sizes:
  - stepH = (SPRITE_H-1)/(N_PROBE-1); stepW = (SPRITE_W-1)/(N_PROBE-1); both integer-truncated.
  - The last probe (k = N_PROBE-1) is forced to offset SPRITE_H-1 (vertical) or SPRITE_W-1 (horizontal).
- Arithmetic:
  - All coordinate math is 11-bit signed.
  - Results saturate to 0..639 for X and 0..479 for Y.
  - An off-screen probe therefore queries the border, which the map reports as wall.
- Each sampled Probe_is_Wall is ORed into the shadow flag of the current edge.
- On the SCAN_D → IDLE transition:
  - shadow flags are copied to Block_*;
  - done pulses.
- Block_* hold their value until the next done, including throughout a scan.
- start while busy=1 is ignored; the latched position is unchanged.
- Reset (any time, including mid-scan):
  - state = IDLE; busy = 0; done = 0; Block_* = 0; Probe_X = Probe_Y = 0;
  - no done is issued for the aborted scan.

## Timing
- Start accepted at edge E0. Probe k of edge e is valid on Probe_X/Probe_Y after edge E(e·N_PROBE+k). It is sampled at the following edge.
- Probe_is_Wall must settle within one cycle of a probe coordinate change; the map-query instance is combinational.
- done and Block_* update at edge E(4·N_PROBE); that is 16 cycles for the default.
- busy is high from after E0 until E(4·N_PROBE); busy=0 in the cycle done is high.
- start asserted in the done cycle is accepted (back-to-back scans, period 4·N_PROBE+1).

## Structure
- wall_probe_pkg holds:
  - the state enum;
  - SCREEN_W = 640, SCREEN_H = 480, MAX_X = 639, MAX_Y = 479;
  - an edge enum L/R/U/D.
- Sub-module probe_coord_gen: combinational. It takes the latched position, edge and k, and returns the saturated Probe_X/Probe_Y next values.
- The FSM, index counter, shadow flags and output registers live in wall_probe.

## Test plan
All scenarios use defaults (20×30, N_PROBE = 4) with the production map instance as responder.
- Pos (300,200), start → done exactly 16 cycles after the start edge; all Block_* = 0.
- Pos (300,425) → bottom probes hit Y = 455 (floor); Block_D = 1, others 0.
- Pos (25,200) → left probes hit X = 24 (left wall); Block_L = 1, others 0.
- Pos (100,361) → bottom probes hit Y = 391 (Fireboy platform); Block_D = 1.
- Pos (545,395) → right probes at X = 565, Y = 395/404/413/424; the last probe hits the test block, so Block_R = 1 and Block_D = 0.
- Control and edge cases, each a separate run:
  - Pos (0,0): Probe_X/Probe_Y saturate to 0, giving Block_L = Block_U = 1.
  - start re-pulsed at cycle 5: ignored, done still at cycle 16.
  - Reset_n low at cycle 8: no done, all outputs 0.
